// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the shared RV32I
// datapath / unified memory port. The sequencer takes the master modport,
// the datapath and memory take the slave modport.
interface multicycle_ctrl_fsm_if;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        adr_src;
  logic        mem_req;
  logic        mem_we;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [1:0]  result_src;
  logic        reg_write;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output pc_write, pc_src, ir_write, adr_src, mem_req, mem_we, alu_src,
           alu_op, result_src, reg_write, halted, trap, trap_cause, instret
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  pc_write, pc_src, ir_write, adr_src, mem_req, mem_we, alu_src,
           alu_op, result_src, reg_write, halted, trap, trap_cause, instret
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer for the RV32I core: steps the shared datapath through
// fetch / decode / execute / memory / writeback, traps on illegal opcodes and
// stalled memory, halts on ECALL/EBREAK and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // A zero MEM_TIMEOUT disables the watchdog; otherwise trap on the last
  // allowed wait cycle if the memory still has not answered.
  localparam bit         TMO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [7:0] TMO_LIMIT = (MEM_TIMEOUT == 0) ? 8'd0 : 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
    S_MEM, S_MEMWB, S_BRANCH, S_JUMP, S_HALT, S_TRAP
  } state_t;

  state_t      state, state_next;
  logic [6:0]  opc_q;
  logic [7:0]  tmo_cnt;
  logic [1:0]  cause_q, cause_set;
  logic [31:0] instret_q;
  logic        retire;
  logic        tmo_hit;
  logic        is_itype, is_store, is_jal;

  assign is_itype = (opc_q == OP_I);
  assign is_store = (opc_q == OP_STORE);
  assign is_jal   = (opc_q == OP_JAL);
  assign tmo_hit  = TMO_EN && !bus.mem_ready && (tmo_cnt == TMO_LIMIT);

  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;

  // Next-state and Moore/Mealy control decode; everything idles at 0.
  always_comb begin
    state_next     = state;
    cause_set      = 2'b00;
    retire         = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_op     = 2'b00;
    bus.result_src = 2'b00;
    bus.reg_write  = 1'b0;
    bus.halted     = 1'b0;
    bus.trap       = 1'b0;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          state_next   = S_DECODE;
        end else if (tmo_hit) begin
          cause_set  = CAUSE_TIMEOUT;
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_R, OP_I:         state_next = S_EXEC;
          OP_LOAD, OP_STORE:  state_next = S_MEMADR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL, OP_JALR:    state_next = S_JUMP;
          OP_SYSTEM:          state_next = S_HALT;
          default: begin
            cause_set  = CAUSE_ILLEGAL;
            state_next = S_TRAP;
          end
        endcase
      end
      S_EXEC: begin
        bus.alu_op  = 2'b10;
        bus.alu_src = is_itype;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        bus.alu_op    = 2'b10;
        bus.alu_src   = is_itype;
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMADR: begin
        bus.alu_src = 1'b1;
        state_next  = S_MEM;
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        bus.alu_src = 1'b1;
        bus.mem_we  = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            state_next   = S_FETCH;
          end else begin
            state_next = S_MEMWB;
          end
        end else if (tmo_hit) begin
          cause_set  = CAUSE_TIMEOUT;
          state_next = S_TRAP;
        end
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 2'b01;
        bus.pc_write   = 1'b1;
        retire         = 1'b1;
        state_next     = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_op   = 2'b01;
        bus.pc_write = 1'b1;
        bus.pc_src   = bus.branch_taken ? 2'b01 : 2'b00;
        retire       = 1'b1;
        state_next   = S_FETCH;
      end
      S_JUMP: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 2'b10;
        bus.alu_src    = 1'b1;
        bus.pc_write   = 1'b1;
        bus.pc_src     = is_jal ? 2'b01 : 2'b10;
        retire         = 1'b1;
        state_next     = S_FETCH;
      end
      S_HALT:  bus.halted = 1'b1;
      S_TRAP:  bus.trap   = 1'b1;
      default: state_next = S_RESET;
    endcase
  end

  // State register; reset drops any in-flight memory request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_next;
  end

  // Opcode snapshot taken in DECODE so later phases ignore IR changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 opc_q <= 7'd0;
    else if (state == S_DECODE) opc_q <= bus.opcode;
  end

  // Memory wait counter: runs only while a request is stalled, else zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= 8'd0;
    else if ((state == S_FETCH || state == S_MEM) && !bus.mem_ready)
      tmo_cnt <= tmo_cnt + 8'd1;
    else
      tmo_cnt <= 8'd0;
  end

  // Trap cause is captured once on the way into TRAP and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cause_q <= 2'b00;
    else if (cause_set != 2'b00) cause_q <= cause_set;
  end

  // Retired-instruction counter, free-running wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm: builds an expected per-cycle control
// trace for each instruction class from its phase list and drives a
// randomly stalling memory, random branch outcomes and IR noise.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned TMO = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_we;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       reg_write;
    logic       halted;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  typedef struct {
    logic       rdy;
    logic       tkn;
    logic [6:0] opc;
    ctl_t       exp;
    bit         ret;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cycle_no = 0;
  logic [31:0] model_instret = 32'd0;
  string       cur_name = "reset";
  cyc_t        plan[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t sample_ctl();
    ctl_t s;
    s.pc_write   = bus.pc_write;
    s.pc_src     = bus.pc_src;
    s.ir_write   = bus.ir_write;
    s.adr_src    = bus.adr_src;
    s.mem_req    = bus.mem_req;
    s.mem_we     = bus.mem_we;
    s.alu_src    = bus.alu_src;
    s.alu_op     = bus.alu_op;
    s.result_src = bus.result_src;
    s.reg_write  = bus.reg_write;
    s.halted     = bus.halted;
    s.trap       = bus.trap;
    s.trap_cause = bus.trap_cause;
    return s;
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic add_cycle(input logic rdy, input logic tkn, input logic [6:0] opc,
                           input ctl_t exp, input bit ret);
    cyc_t c;
    c.rdy = rdy;
    c.tkn = tkn;
    c.opc = opc;
    c.exp = exp;
    c.ret = ret;
    plan.push_back(c);
  endtask

  // Fetch with a given number of stall cycles, then DECODE seeing opc.
  task automatic plan_fetch(input int waits, input logic [6:0] opc);
    ctl_t f;
    f = '0;
    f.mem_req = 1'b1;
    for (int w = 0; w < waits; w++) add_cycle(1'b0, rbit(), junk(), f, 1'b0);
    f.ir_write = 1'b1;
    add_cycle(1'b1, rbit(), junk(), f, 1'b0);
    add_cycle(rbit(), rbit(), opc, '0, 1'b0);
  endtask

  // Phase list of one legal, non-system instruction after decode.
  task automatic plan_instr(input logic [6:0] opc, input int fw, input int mw, input logic tkn);
    ctl_t v;
    plan_fetch(fw, opc);
    v = '0;
    if (opc == OP_R || opc == OP_I) begin
      v.alu_op  = 2'b10;
      v.alu_src = (opc == OP_I);
      add_cycle(rbit(), rbit(), junk(), v, 1'b0);
      v.reg_write = 1'b1;
      v.pc_write  = 1'b1;
      add_cycle(rbit(), rbit(), junk(), v, 1'b1);
    end else if (opc == OP_LOAD || opc == OP_STORE) begin
      v.alu_src = 1'b1;
      add_cycle(rbit(), rbit(), junk(), v, 1'b0);
      v.mem_req = 1'b1;
      v.adr_src = 1'b1;
      v.mem_we  = (opc == OP_STORE);
      for (int w = 0; w < mw; w++) add_cycle(1'b0, rbit(), junk(), v, 1'b0);
      v.pc_write = (opc == OP_STORE);
      add_cycle(1'b1, rbit(), junk(), v, opc == OP_STORE);
      if (opc == OP_LOAD) begin
        v = '0;
        v.reg_write  = 1'b1;
        v.result_src = 2'b01;
        v.pc_write   = 1'b1;
        add_cycle(rbit(), rbit(), junk(), v, 1'b1);
      end
    end else if (opc == OP_BRANCH) begin
      v.alu_op   = 2'b01;
      v.pc_write = 1'b1;
      v.pc_src   = tkn ? 2'b01 : 2'b00;
      add_cycle(rbit(), tkn, junk(), v, 1'b1);
    end else begin
      v.reg_write  = 1'b1;
      v.result_src = 2'b10;
      v.alu_src    = 1'b1;
      v.pc_write   = 1'b1;
      v.pc_src     = (opc == OP_JAL) ? 2'b01 : 2'b10;
      add_cycle(rbit(), rbit(), junk(), v, 1'b1);
    end
  endtask

  task automatic plan_stuck(input int n, input logic hlt, input logic [1:0] cause);
    ctl_t v;
    v = '0;
    v.halted     = hlt;
    v.trap       = !hlt;
    v.trap_cause = cause;
    repeat (n) add_cycle(rbit(), rbit(), junk(), v, 1'b0);
  endtask

  task automatic applyStimulus(input cyc_t c);
    bus.mem_ready    = c.rdy;
    bus.branch_taken = c.tkn;
    bus.opcode       = c.opc;
  endtask

  task automatic run_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk);
      #1 applyStimulus(c);
      #1;
      cycle_no++;
      checkOutput($sformatf("ctl %s cyc %0d", cur_name, cycle_no), {15'd0, sample_ctl()}, {15'd0, c.exp});
      checkOutput($sformatf("instret %s cyc %0d", cur_name, cycle_no), bus.instret, model_instret);
      if (c.ret) model_instret = model_instret + 32'd1;
    end
  endtask

  task automatic release_reset();
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.opcode       = 7'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ctl in RESET state", {15'd0, sample_ctl()}, 32'd0);
    checkOutput("instret in RESET state", bus.instret, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    checkOutput($sformatf("instret end of %s", cur_name), bus.instret, model_instret);
    rst_n = 1'b0;
    #1;
    checkOutput("ctl during reset", {15'd0, sample_ctl()}, 32'd0);
    checkOutput("instret during reset", bus.instret, 32'd0);
    model_instret = 32'd0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  initial begin : main
    logic [6:0] legal[7];
    ctl_t       f;
    legal = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};

    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.opcode       = 7'd0;
    repeat (3) @(posedge clk);
    release_reset();

    cur_name = "ADD";   plan_instr(OP_R, 0, 0, 1'b0);      run_plan();
    cur_name = "LW";    plan_instr(OP_LOAD, 0, 3, 1'b0);   run_plan();
    cur_name = "BEQ_T"; plan_instr(OP_BRANCH, 0, 0, 1'b1); run_plan();
    cur_name = "BEQ_N"; plan_instr(OP_BRANCH, 1, 0, 1'b0); run_plan();
    cur_name = "JALR";  plan_instr(OP_JALR, 0, 0, 1'b0);   run_plan();
    cur_name = "JAL";   plan_instr(OP_JAL, 2, 0, 1'b0);    run_plan();
    cur_name = "SW";    plan_instr(OP_STORE, 3, 3, 1'b0);  run_plan();

    for (int i = 0; i < 40; i++) begin
      cur_name = $sformatf("rnd%0d", i);
      plan_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 3),
                 $urandom_range(0, 3), rbit());
      run_plan();
    end

    cur_name = "ILLEGAL";
    plan_fetch(1, 7'b0000000);
    plan_stuck(6, 1'b0, 2'b01);
    run_plan();
    do_reset();
    cur_name = "ADDI after trap"; plan_instr(OP_I, 0, 0, 1'b0); run_plan();

    cur_name = "FETCH timeout";
    f = '0;
    f.mem_req = 1'b1;
    repeat (TMO) add_cycle(1'b0, rbit(), junk(), f, 1'b0);
    plan_stuck(5, 1'b0, 2'b10);
    run_plan();
    do_reset();

    cur_name = "MEM timeout";
    plan_fetch(0, OP_LOAD);
    f = '0;
    f.alu_src = 1'b1;
    add_cycle(1'b0, rbit(), junk(), f, 1'b0);
    f.mem_req = 1'b1;
    f.adr_src = 1'b1;
    repeat (TMO) add_cycle(1'b0, rbit(), junk(), f, 1'b0);
    plan_stuck(4, 1'b0, 2'b10);
    run_plan();
    do_reset();

    cur_name = "pre-ECALL"; plan_instr(OP_R, 0, 0, 1'b0); run_plan();
    cur_name = "ECALL";
    plan_fetch(0, OP_SYSTEM);
    plan_stuck(6, 1'b1, 2'b00);
    run_plan();
    do_reset();

    cur_name = "final ADD"; plan_instr(OP_R, 1, 0, 1'b0); run_plan();
    @(posedge clk);
    #2 checkOutput("instret final", bus.instret, model_instret);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I core.
- Replaces single-cycle opcode decode with a state machine that steps the shared datapath through fetch, decode, execute, memory and writeback.
- Drives PC/IR enables, the unified memory request handshake, and the register-file, ALU and mux selects.
- Detects illegal opcodes and memory timeouts, halts on ECALL/EBREAK, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles per memory access before a bus trap; 0 disables the timeout; legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from the cycle after ir_write.
- branch_taken  in  1  branch comparator result; valid in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_write  out  1  PC register enable.
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result.
- ir_write  out  1  IR load enable.
- adr_src  out  1  memory address: 0 PC, 1 ALU result.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier; valid only with mem_req.
- alu_src  out  1  ALU operand B: 0 rs2, 1 immediate.
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded.
- result_src  out  2  writeback source: 00 ALU, 01 memory data, 10 PC+4.
- reg_write  out  1  register-file write enable.
- halted  out  1  sticky; ECALL/EBREAK executed.
- trap  out  1  sticky; fault occurred.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout.
- instret  out  32  retired-instruction count.

Behaviour:
- States: RESET, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEM, MEMWB, BRANCH, JUMP, HALT, TRAP.
- Default output value is 0 unless listed for a state. Outputs are decoded from the state; pc_write, pc_src, ir_write and the retire pulse are additionally qualified by mem_ready/branch_taken.

Reset:
- rst_n low forces RESET immediately.
- Reset clears instret, the timeout counter, the latched opcode, halted, trap and trap_cause.
- RESET drives all outputs 0 and moves to FETCH on the first clock after rst_n rises.
- Reset mid-access abandons the request; mem_req drops asynchronously.

State actions and transitions:
- FETCH: mem_req=1, adr_src=0, mem_we=0. On mem_ready: ir_write=1 for that cycle only, then DECODE.
- DECODE: latch opcode internally; the latched copy is used until the next FETCH. Next state by opcode:
  - 0110011 / 0010011 → EXEC
  - 0000011 / 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 / 1100111 → JUMP
  - 1110011 → HALT
  - other → TRAP with cause 01
- EXEC: alu_op=10; alu_src=0 for R-type, 1 for I-type. Next: ALUWB.
- ALUWB: reg_write=1, result_src=00, alu_op/alu_src held from EXEC, pc_write=1, pc_src=00, retire. Next: FETCH.
- MEMADR: alu_src=1, alu_op=00. Next: MEM.
- MEM: mem_req=1, adr_src=1, alu_src=1, alu_op=00, mem_we=1 for store. On mem_ready:
  - store: pc_write=1, pc_src=00, retire, then FETCH.
  - load: MEMWB.
- MEMWB: reg_write=1, result_src=01, pc_write=1, pc_src=00, retire. Next: FETCH.
- BRANCH: alu_src=0, alu_op=01, pc_write=1, pc_src = branch_taken ? 01 : 00, retire. Next: FETCH.
- JUMP: reg_write=1, result_src=10, alu_src=1, alu_op=00, pc_write=1, pc_src = JAL ? 01 : 10, retire. Next: FETCH.
- HALT: halted=1; absorbing until reset. ECALL does not retire.
- TRAP: trap=1, trap_cause held; absorbing until reset.

Latency with zero-wait memory:
- ALU / store: 4 cycles.
- load: 5 cycles.
- branch / jump: 3 cycles.

Timeout counter:
- 8-bit; cleared on entry to FETCH or MEM and whenever mem_ready=1; increments each FETCH/MEM cycle with mem_ready=0.
- When the count equals MEM_TIMEOUT-1 and mem_ready=0 → TRAP, cause 10.
- mem_ready arriving in the limit cycle wins over the timeout.

instret:
- +1 on each retire cycle; wraps 0xFFFFFFFF → 0.

Test Plan:
- Reset release, memory always ready, IR=ADD (0110011): cycle 1 RESET, FETCH with mem_req=1 adr_src=0, ir_write pulse, DECODE, EXEC alu_op=10 alu_src=0, ALUWB reg_write=1 pc_write=1 pc_src=00 → instret=1 after 4 instruction cycles.
- LW with mem_ready delayed 3 cycles in MEM: MEM holds mem_req=1 adr_src=1 mem_we=0 for 4 cycles, then MEMWB result_src=01 reg_write=1 → instret +1, total 8 cycles.
- BEQ with branch_taken=1, then BEQ with branch_taken=0 → pc_src=01 then 00, pc_write=1 each; reg_write never set.
- JALR (1100111) → JUMP: pc_src=10, result_src=10, reg_write=1. JAL (1101111) → pc_src=01.
- Opcode 0000000 → TRAP, trap=1, trap_cause=01; subsequent clocks stay in TRAP; rst_n pulse low clears trap and instret, and the next instruction fetches normally.
- MEM_TIMEOUT=4, mem_ready held low in FETCH → TRAP cause 10 after exactly 4 FETCH cycles. ECALL (1110011) → halted=1, instret unchanged, mem_req stays 0.
